// File: rtl/mips_pkg.sv
// Shared MIPS definitions: word width, PC increment and the fetch FSM
// state encoding, plus a small word-alignment helper.
package mips_pkg;

    localparam int unsigned LARGURA_PALAVRA = 32;

    localparam logic [LARGURA_PALAVRA-1:0] PC_INCREMENTO = 32'd4;

    typedef enum logic [1:0] {
        ESTADO_REQ     = 2'd0,
        ESTADO_ESPERA  = 2'd1,
        ESTADO_ENTREGA = 2'd2,
        ESTADO_ERRO    = 2'd3
    } estado_t;

    function automatic logic alinhado(
        input logic [LARGURA_PALAVRA-1:0] endereco
    );
        return endereco[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/pc_reg.sv
// Program-counter register with synchronous reset to RESET_PC.
// Ports: clock, reset, load (enable), d (next value), q (current PC).
module pc_reg
    import mips_pkg::*;
#(
    parameter logic [LARGURA_PALAVRA-1:0] RESET_PC = '0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       load,
    input  logic [LARGURA_PALAVRA-1:0] d,
    output logic [LARGURA_PALAVRA-1:0] q
);

    always_ff @(posedge clock) begin
        if (reset) begin
            q <= RESET_PC;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_pc.sv
// PC register and instruction-fetch sequencer: one imem read per
// instruction, fetched word handed to decode over valid/ready.
// Ports: clock/reset; proximo_pc in, pc/pc4 out; imem_req_* request
// channel; imem_resp_* response; instr_* decode handshake;
// erro_alinhamento sticky misaligned-PC flag.
module fetch_pc
    import mips_pkg::*;
#(
    parameter logic [LARGURA_PALAVRA-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [LARGURA_PALAVRA-1:0] proximo_pc,
    output logic [LARGURA_PALAVRA-1:0] pc4,
    output logic [LARGURA_PALAVRA-1:0] pc,
    output logic                       imem_req_valid,
    output logic [LARGURA_PALAVRA-1:0] imem_req_addr,
    input  logic                       imem_req_ready,
    input  logic                       imem_resp_valid,
    input  logic [LARGURA_PALAVRA-1:0] imem_resp_data,
    output logic                       instr_valid,
    output logic [LARGURA_PALAVRA-1:0] instr,
    output logic [LARGURA_PALAVRA-1:0] instr_pc,
    input  logic                       instr_ready,
    output logic                       erro_alinhamento
);

    estado_t estado;
    estado_t estado_n;

    logic req_valid_q;
    logic req_valid_n;
    logic instr_valid_q;
    logic instr_valid_n;
    logic erro_q;
    logic erro_n;
    logic carrega_pc;
    logic captura;

    logic [LARGURA_PALAVRA-1:0] instr_q;
    logic [LARGURA_PALAVRA-1:0] instr_pc_q;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clock (clock),
        .reset (reset),
        .load  (carrega_pc),
        .d     (proximo_pc),
        .q     (pc)
    );

    assign pc4           = pc + PC_INCREMENTO;
    assign imem_req_addr = pc;

    always_comb begin
        estado_n   = estado;
        carrega_pc = 1'b0;
        captura    = 1'b0;
        erro_n     = erro_q;

        unique case (estado)
            ESTADO_REQ: begin
                // Valid is held low for the first cycle out of reset,
                // so a handshake can only happen once it is raised.
                if (req_valid_q && imem_req_ready) begin
                    estado_n = ESTADO_ESPERA;
                end
            end
            ESTADO_ESPERA: begin
                if (imem_resp_valid) begin
                    captura  = 1'b1;
                    estado_n = ESTADO_ENTREGA;
                end
            end
            ESTADO_ENTREGA: begin
                if (instr_ready) begin
                    if (alinhado(proximo_pc)) begin
                        carrega_pc = 1'b1;
                        estado_n   = ESTADO_REQ;
                    end else begin
                        erro_n   = 1'b1;
                        estado_n = ESTADO_ERRO;
                    end
                end
            end
            ESTADO_ERRO: begin
                estado_n = ESTADO_ERRO;
            end
        endcase

        // Valids are registered copies of the next state, so neither
        // ready input reaches an output combinationally.
        req_valid_n   = (estado_n == ESTADO_REQ);
        instr_valid_n = (estado_n == ESTADO_ENTREGA);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado        <= ESTADO_REQ;
            req_valid_q   <= 1'b0;
            instr_valid_q <= 1'b0;
            erro_q        <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
        end else begin
            estado        <= estado_n;
            req_valid_q   <= req_valid_n;
            instr_valid_q <= instr_valid_n;
            erro_q        <= erro_n;
            if (captura) begin
                instr_q    <= imem_resp_data;
                instr_pc_q <= pc;
            end
        end
    end

    assign imem_req_valid   = req_valid_q;
    assign instr_valid      = instr_valid_q;
    assign instr            = instr_q;
    assign instr_pc         = instr_pc_q;
    assign erro_alinhamento = erro_q;

endmodule

// File: tb/tb_fetch_pc.sv
// Self-checking bench for fetch_pc: table of fetch transactions with a
// scoreboard queue, plus hand-written reset, error and wrap sequences.
module tb_fetch_pc;

    logic        clock;
    logic        reset;
    logic [31:0] proximo_pc;
    logic [31:0] pc4;
    logic [31:0] pc;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        erro_alinhamento;

    fetch_pc #(
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .proximo_pc       (proximo_pc),
        .pc4              (pc4),
        .pc               (pc),
        .imem_req_valid   (imem_req_valid),
        .imem_req_addr    (imem_req_addr),
        .imem_req_ready   (imem_req_ready),
        .imem_resp_valid  (imem_resp_valid),
        .imem_resp_data   (imem_resp_data),
        .instr_valid      (instr_valid),
        .instr            (instr),
        .instr_pc         (instr_pc),
        .instr_ready      (instr_ready),
        .erro_alinhamento (erro_alinhamento)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] next_pc;
        int          req_stall;
        int          resp_lat;
        int          acc_stall;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[7];
    int   hs_cyc[7];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_req();
        int n = 0;
        while (imem_req_valid !== 1'b1 && n < 8) begin
            step();
            n++;
        end
        check("req_valid_wait", {31'b0, imem_req_valid}, 32'd1);
    endtask

    task automatic fetch(input vec_t v, output int hs);
        exp_t e;
        wait_req();
        check("req_addr", imem_req_addr, v.addr);
        check("pc", pc, v.addr);
        check("pc4", pc4, v.addr + 32'd4);
        imem_req_ready = 1'b0;
        for (int i = 0; i < v.req_stall; i++) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = 32'hDEAD_0000 | 32'(i);
            step();
            check("req_addr_hold", imem_req_addr, v.addr);
            check("req_valid_hold", {31'b0, imem_req_valid}, 32'd1);
        end
        // A response in the handshake cycle must be ignored.
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hBAD0_BAD0;
        imem_req_ready  = 1'b1;
        e.instr = v.data;
        e.pc    = v.addr;
        sb.push_back(e);
        hs = cyc;
        step();
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        check("req_valid_low", {31'b0, imem_req_valid}, 32'd0);
        for (int i = 1; i < v.resp_lat; i++) begin
            step();
            check("instr_valid_early", {31'b0, instr_valid}, 32'd0);
        end
        imem_resp_valid = 1'b1;
        imem_resp_data  = v.data;
        step();
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0BAD_F00D;
        check("instr_valid", {31'b0, instr_valid}, 32'd1);
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard: got empty queue expected entry");
        end else begin
            e = sb.pop_front();
            check("instr", instr, e.instr);
            check("instr_pc", instr_pc, e.pc);
        end
        instr_ready = 1'b0;
        proximo_pc  = 32'h0000_0003;
        for (int i = 0; i < v.acc_stall; i++) begin
            step();
            check("instr_hold", instr, e.instr);
            check("instr_pc_hold", instr_pc, e.pc);
            check("instr_valid_hold", {31'b0, instr_valid}, 32'd1);
            check("pc_hold", pc, v.addr);
        end
        proximo_pc  = v.next_pc;
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        check("instr_valid_drop", {31'b0, instr_valid}, 32'd0);
        if (v.next_pc[1:0] != 2'b00) begin
            check("erro_set", {31'b0, erro_alinhamento}, 32'd1);
            check("req_valid_err", {31'b0, imem_req_valid}, 32'd0);
            check("pc_err", pc, v.addr);
        end else begin
            check("erro_clear", {31'b0, erro_alinhamento}, 32'd0);
            check("pc_next", pc, v.next_pc);
            check("req_valid_next", {31'b0, imem_req_valid}, 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   hs;
        vec_t v;

        vecs[0] = '{32'h0000_0000, 32'h2008_0005, 32'h0000_0004, 0, 1, 0};
        vecs[1] = '{32'h0000_0004, 32'h2009_000A, 32'h0000_0008, 0, 1, 0};
        vecs[2] = '{32'h0000_0008, 32'h1000_000D, 32'h0000_0040, 0, 1, 0};
        vecs[3] = '{32'h0000_0040, 32'h8C0B_0010, 32'h0000_0044, 3, 2, 4};
        vecs[4] = '{32'h0000_0044, 32'hAC0C_0020, 32'hFFFF_FFFC, 0, 3, 1};
        vecs[5] = '{32'hFFFF_FFFC, 32'h0800_0000, 32'h0000_0000, 1, 1, 0};
        vecs[6] = '{32'h0000_0000, 32'h2008_0005, 32'h0000_0046, 0, 1, 2};

        reset           = 1'b1;
        proximo_pc      = '0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        instr_ready     = 1'b0;

        step();
        step();
        check("rst_pc", pc, 32'h0);
        check("rst_pc4", pc4, 32'h4);
        check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_instr", instr, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);
        check("rst_erro", {31'b0, erro_alinhamento}, 32'd0);
        reset = 1'b0;
        step();
        check("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("first_req_addr", imem_req_addr, 32'h0);

        for (int i = 0; i < 7; i++) begin
            fetch(vecs[i], hs);
            hs_cyc[i] = hs;
        end
        check("throughput_0_1", 32'(hs_cyc[1] - hs_cyc[0]), 32'd3);
        check("throughput_1_2", 32'(hs_cyc[2] - hs_cyc[1]), 32'd3);

        // ERRO is terminal: no input may revive a request.
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b1;
        instr_ready     = 1'b1;
        proximo_pc      = 32'h0000_0008;
        for (int i = 0; i < 3; i++) begin
            step();
            check("erro_sticky", {31'b0, erro_alinhamento}, 32'd1);
            check("erro_no_req", {31'b0, imem_req_valid}, 32'd0);
            check("erro_no_instr", {31'b0, instr_valid}, 32'd0);
            check("erro_pc", pc, 32'h0);
        end
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        instr_ready     = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        sb.delete();
        check("erro_cleared", {31'b0, erro_alinhamento}, 32'd0);
        check("erro_rst_req", {31'b0, imem_req_valid}, 32'd0);
        step();
        check("erro_rst_req_up", {31'b0, imem_req_valid}, 32'd1);

        // Reset while waiting on memory; late response must be dropped.
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        check("mid_req_low", {31'b0, imem_req_valid}, 32'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        sb.delete();
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hFEED_FACE;
        step();
        imem_resp_valid = 1'b0;
        check("mid_instr_valid", {31'b0, instr_valid}, 32'd0);
        check("mid_instr", instr, 32'h0);
        check("mid_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("mid_req_addr", imem_req_addr, 32'h0);

        v = '{32'h0000_0000, 32'h2008_0005, 32'h0000_0004, 0, 1, 0};
        fetch(v, hs);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
